// File: rtl/acquisition_sequencer.sv
// ADC acquisition sequencer: arm on run/single, capture NUM_SAMPLES after a trigger,
// hand the buffer to the UART serializer for SEND_TICKS baud ticks, then hold off and re-arm.
module acquisition_sequencer #(
  parameter int NUM_SAMPLES      = 2000,
  parameter int ADDR_W           = 11,
  parameter int SEND_TICKS       = 72037,
  parameter int HOLDOFF_CYCLES   = 1000,
  parameter int AUTO_TRIG_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              single,
  input  logic              abort,
  input  logic              trigger,
  input  logic              sample_valid,
  input  logic              baud_tick,
  output logic              acquire,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wave_number,
  output logic              busy,
  output logic [2:0]        state,
  output logic [7:0]        missed_trig
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  localparam int ARM_W  = (AUTO_TRIG_CYCLES > 1) ? $clog2(AUTO_TRIG_CYCLES) : 1;
  localparam int TICK_W = (SEND_TICKS > 1)       ? $clog2(SEND_TICKS)       : 1;
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1)   ? $clog2(HOLDOFF_CYCLES)   : 1;

  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'((AUTO_TRIG_CYCLES > 0) ? AUTO_TRIG_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] SAMP_LAST = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SEND_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  state_t              cur, nxt;
  logic [ARM_W-1:0]    arm_cnt;
  logic [ADDR_W-1:0]   samp_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                single_q;
  logic                trig_q;

  logic                trig_edge, auto_fire, last_sample, last_tick, hold_done;

  logic                acquire_d, wr_en_d, busy_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [15:0]         wave_d;
  logic [7:0]          missed_d;

  assign trig_edge   = trigger & ~trig_q;
  assign auto_fire   = (AUTO_TRIG_CYCLES != 0) && (arm_cnt == ARM_LAST);
  assign last_sample = sample_valid && (samp_cnt == SAMP_LAST);
  assign last_tick   = baud_tick && (tick_cnt == TICK_LAST);
  assign hold_done   = (hold_cnt == HOLD_LAST);
  assign state       = cur;

  // State and counters; counters reset whenever their state is left, so abort clears them too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= S_IDLE;
      arm_cnt  <= '0;
      samp_cnt <= '0;
      tick_cnt <= '0;
      hold_cnt <= '0;
      single_q <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      cur      <= nxt;
      trig_q   <= trigger;
      arm_cnt  <= (cur == S_ARM && nxt == S_ARM) ? arm_cnt + 1'b1 : '0;
      samp_cnt <= (cur == S_CAPTURE && nxt == S_CAPTURE) ? samp_cnt + ADDR_W'(sample_valid) : '0;
      tick_cnt <= (cur == S_SEND && nxt == S_SEND) ? tick_cnt + TICK_W'(baud_tick) : '0;
      hold_cnt <= (cur == S_HOLDOFF && nxt == S_HOLDOFF) ? hold_cnt + 1'b1 : '0;
      if (abort || (cur == S_HOLDOFF && nxt != S_HOLDOFF))
        single_q <= 1'b0;
      else if (cur == S_IDLE && single && !run)
        single_q <= 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (cur)
        S_IDLE:    if (run || single)          nxt = S_ARM;
        S_ARM:     if (trig_edge || auto_fire) nxt = S_CAPTURE;
        S_CAPTURE: if (last_sample)            nxt = S_SEND;
        S_SEND:    if (last_tick)              nxt = S_HOLDOFF;
        // A single-shot cycle ends in IDLE even if run rose meanwhile; IDLE re-arms on run next cycle.
        S_HOLDOFF: if (hold_done)              nxt = (run && !single_q) ? S_ARM : S_IDLE;
        default:                               nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    acquire_d = (nxt != S_SEND);
    busy_d    = (nxt != S_IDLE);
    wr_en_d   = !abort && (cur == S_CAPTURE) && sample_valid;
    wr_addr_d = wr_addr;
    if (abort || (cur == S_ARM && nxt == S_CAPTURE))
      wr_addr_d = '0;
    else if (wr_en_d)
      wr_addr_d = samp_cnt;
    wave_d    = wave_number + 16'((cur == S_SEND) && (nxt == S_HOLDOFF));
    missed_d  = missed_trig;
    if (!abort && trig_edge && missed_trig != 8'hFF &&
        (cur == S_CAPTURE || cur == S_SEND || cur == S_HOLDOFF))
      missed_d = missed_trig + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acquire     <= 1'b1;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wave_number <= '0;
      busy        <= 1'b0;
      missed_trig <= '0;
    end else begin
      acquire     <= acquire_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wave_number <= wave_d;
      busy        <= busy_d;
      missed_trig <= missed_d;
    end
  end

endmodule
